// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage between execute and write-back.
// Performs load/store on a 16-bit data memory and 16/32-bit stack push/pop;
// 32-bit stack ops take two cycles and stall the upstream stage for one.
// Optional feature macro: STACK_GUARD_EN (stack overflow/underflow guard).
module memory_stage #(
    parameter int unsigned       ADDR_W  = 11,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              InValid,
    input  logic [2:0]        MemOp,
    input  logic [31:0]       Address,
    input  logic [31:0]       DataIn,
    output logic              Stall,
    output logic              OutValid,
    output logic [31:0]       Result,
    output logic [ADDR_W-1:0] SP,
    output logic              StackFault
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_PUSH16 = 3'd3;
    localparam logic [2:0] OP_POP16  = 3'd4;
    localparam logic [2:0] OP_PUSH32 = 3'd5;
    localparam logic [2:0] OP_POP32  = 3'd6;

    localparam logic [ADDR_W-1:0] SP_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] SP_ZERO = {ADDR_W{1'b0}};

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    // 16 -> 32 sign extension of a memory word
    function automatic logic [31:0] sext16(input logic [15:0] w);
        return {{16{w[15]}}, w};
    endfunction

    logic [15:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [31:0]       result_q, result_d;
    logic              out_valid_q, out_valid_d;
    logic              fault_q, fault_d;
    logic [15:0]       hi_q, hi_d;
    logic              pop_q, pop_d;

    logic [ADDR_W-1:0] sp_inc_s;
    logic [ADDR_W-1:0] sp_dec_s;
    logic [15:0]       ld_word_s;
    logic [15:0]       pop_word_s;
    logic              guard_fault_s;
    logic              is_wide_s;
    logic              wr_req_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [15:0]       mem_wdata_s;
    logic              unused_addr_s;

    assign sp_inc_s      = sp_q + SP_ONE;
    assign sp_dec_s      = sp_q - SP_ONE;
    assign ld_word_s     = mem[Address[ADDR_W-1:0]];
    assign pop_word_s    = mem[sp_inc_s];
    assign is_wide_s     = (MemOp == OP_PUSH32) || (MemOp == OP_POP32);
    assign unused_addr_s = ^Address[31:ADDR_W];

`ifdef STACK_GUARD_EN
    // Stack bound check for the op presented in IDLE; a faulted op is a one-cycle no-op.
    always_comb begin
        guard_fault_s = 1'b0;
        if ((state_q == ST_IDLE) && InValid) begin
            case (MemOp)
                OP_PUSH16: guard_fault_s = (sp_q == SP_ZERO);
                OP_PUSH32: guard_fault_s = (sp_q <= SP_ONE);
                OP_POP16:  guard_fault_s = (sp_q == SP_INIT);
                OP_POP32:  guard_fault_s = (sp_q >= (SP_INIT - SP_ONE));
                default:   guard_fault_s = 1'b0;
            endcase
        end else begin
            guard_fault_s = 1'b0;
        end
    end
`else
    assign guard_fault_s = 1'b0;
`endif

    // Upstream must hold its outputs while the first half of a 32-bit op executes.
    assign Stall = (state_q == ST_IDLE) & InValid & is_wide_s & ~guard_fault_s;

    // Next-state, memory write port and result computation for both phases.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        fault_d     = 1'b0;
        hi_d        = hi_q;
        pop_d       = pop_q;
        wr_req_s    = 1'b0;
        mem_waddr_s = sp_q;
        mem_wdata_s = DataIn[15:0];
        case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    out_valid_d = 1'b1;
                    if (guard_fault_s) begin
                        result_d = 32'h0000_0000;
                        fault_d  = 1'b1;
                    end else begin
                        case (MemOp)
                            OP_LOAD: begin
                                result_d = sext16(ld_word_s);
                            end
                            OP_STORE: begin
                                wr_req_s    = 1'b1;
                                mem_waddr_s = Address[ADDR_W-1:0];
                                result_d    = 32'h0000_0000;
                            end
                            OP_PUSH16: begin
                                wr_req_s = 1'b1;
                                sp_d     = sp_dec_s;
                                result_d = 32'h0000_0000;
                            end
                            OP_POP16: begin
                                result_d = sext16(pop_word_s);
                                sp_d     = sp_inc_s;
                            end
                            OP_PUSH32: begin
                                // low word first so the high word ends up on top
                                wr_req_s    = 1'b1;
                                sp_d        = sp_dec_s;
                                hi_d        = DataIn[31:16];
                                pop_d       = 1'b0;
                                out_valid_d = 1'b0;
                                state_d     = ST_SECOND;
                            end
                            OP_POP32: begin
                                // top of stack holds the high word
                                hi_d        = pop_word_s;
                                sp_d        = sp_inc_s;
                                pop_d       = 1'b1;
                                out_valid_d = 1'b0;
                                state_d     = ST_SECOND;
                            end
                            default: begin
                                result_d = DataIn;
                            end
                        endcase
                    end
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_SECOND: begin
                // InValid here is the upstream's held copy of the same op
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
                if (pop_q) begin
                    result_d = {hi_q, pop_word_s};
                    sp_d     = sp_inc_s;
                end else begin
                    wr_req_s    = 1'b1;
                    mem_wdata_s = hi_q;
                    sp_d        = sp_dec_s;
                    result_d    = 32'h0000_0000;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // no writes land while reset is held
        mem_we_s = wr_req_s & rst;
    end

    // Data memory write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Pipeline registers toward write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sp_q        <= SP_INIT;
            result_q    <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            hi_q        <= 16'h0000;
            pop_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            fault_q     <= fault_d;
            hi_q        <= hi_d;
            pop_q       <= pop_d;
        end
    end

    assign OutValid   = out_valid_q;
    assign Result     = result_q;
    assign SP         = sp_q;
    assign StackFault = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed + randomized bench for memory_stage with a
// transaction-level reference model (flat memory array, stack pointer, result).
// Honours STACK_GUARD_EN the same way the design does.
module tb_memory_stage;

    localparam logic [10:0] SP_INIT = 11'h7FF;
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_PUSH16 = 3'd3;
    localparam logic [2:0] OP_POP16  = 3'd4;
    localparam logic [2:0] OP_PUSH32 = 3'd5;
    localparam logic [2:0] OP_POP32  = 3'd6;
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        InValid;
    logic [2:0]  MemOp;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic        Stall;
    logic        OutValid;
    logic [31:0] Result;
    logic [10:0] SP;
    logic        StackFault;

    memory_stage dut (
        .clk(clk), .rst(rst), .InValid(InValid), .MemOp(MemOp),
        .Address(Address), .DataIn(DataIn), .Stall(Stall),
        .OutValid(OutValid), .Result(Result), .SP(SP), .StackFault(StackFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [15:0] mm [2048];
    bit          mk [2048];
    logic [10:0] m_sp;
    logic [31:0] m_res;
    bit          m_known;

    // expected outputs: pend_* describe the state after the next rising edge
    bit          pend_ov, pend_fault, pend_known;
    logic [31:0] pend_res;
    logic [10:0] pend_sp;
    bit          exp_ov, exp_fault, exp_known;
    logic [31:0] exp_res;
    logic [10:0] exp_sp;
    bit          cur_stall;
    bit          checking;

    int n_vec;
    int n_err;

    function automatic logic [31:0] sx(input logic [15:0] w);
        return {{16{w[15]}}, w};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    always @(posedge clk) begin
        exp_ov    <= pend_ov;
        exp_fault <= pend_fault;
        exp_known <= pend_known;
        exp_res   <= pend_res;
        exp_sp    <= pend_sp;
    end

    // per-cycle comparison against the model, away from the rising edge
    always begin
        @(negedge clk);
        #1;
        if (checking) begin
            chk("stall", {31'h0, Stall}, {31'h0, cur_stall});
            chk("out_valid", {31'h0, OutValid}, {31'h0, exp_ov});
            chk("stack_fault", {31'h0, StackFault}, {31'h0, exp_fault});
            chk("sp", {21'h0, SP}, {21'h0, exp_sp});
            if (exp_known) chk("result", Result, exp_res);
        end
    end

    task automatic set_all_reset();
        m_sp = SP_INIT; m_res = 32'h0; m_known = 1'b1;
        pend_ov = 1'b0; pend_fault = 1'b0; pend_known = 1'b1; pend_res = 32'h0; pend_sp = SP_INIT;
        exp_ov = 1'b0; exp_fault = 1'b0; exp_known = 1'b1; exp_res = 32'h0; exp_sp = SP_INIT;
        cur_stall = 1'b0;
    endtask

    // called at a falling edge; returns at a falling edge with reset released
    task automatic do_reset();
        rst = 1'b0;
        InValid = 1'b0;
        set_all_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // called at a falling edge; applies one op and returns at the falling edge
    // after its completion edge (or after a reset if abort is set on a 32-bit op)
    task automatic issue(input logic [2:0] op, input logic [10:0] addr,
                         input logic [31:0] data, input bit abort);
        logic [10:0] s, a1, a2, am1, mid;
        logic [31:0] r, hi_bits;
        bit f, k, is32;
        s = m_sp; a1 = s + 11'd1; a2 = s + 11'd2; am1 = s - 11'd1;
        r = 32'h0; k = 1'b1; f = 1'b0; is32 = 1'b0; mid = s;
        if (GUARD) begin
            case (op)
                OP_PUSH16: f = (s == 11'd0);
                OP_PUSH32: f = (s <= 11'd1);
                OP_POP16:  f = (s == SP_INIT);
                OP_POP32:  f = (s >= SP_INIT - 11'd1);
                default:   f = 1'b0;
            endcase
        end
        if (!f) begin
            case (op)
                OP_LOAD:   begin r = sx(mm[addr]); k = mk[addr]; end
                OP_STORE:  begin mm[addr] = data[15:0]; mk[addr] = 1'b1; end
                OP_PUSH16: begin mm[s] = data[15:0]; mk[s] = 1'b1; s = am1; end
                OP_POP16:  begin r = sx(mm[a1]); k = mk[a1]; s = a1; end
                OP_PUSH32: begin
                    is32 = 1'b1; mm[s] = data[15:0]; mk[s] = 1'b1; mid = am1;
                    if (!abort) begin mm[am1] = data[31:16]; mk[am1] = 1'b1; end
                    s = s - 11'd2;
                end
                OP_POP32:  begin
                    is32 = 1'b1; r = {mm[a1], mm[a2]}; k = mk[a1] & mk[a2];
                    mid = a1; s = a2;
                end
                default:   r = data;
            endcase
        end
        hi_bits = $urandom;
        InValid = 1'b1; MemOp = op; DataIn = data;
        Address = {hi_bits[31:11], addr};
        cur_stall = is32;
        if (is32) begin
            pend_ov = 1'b0; pend_fault = 1'b0; pend_sp = mid;
            @(negedge clk);
            if (abort) begin
                do_reset();
                return;
            end
            cur_stall = 1'b0;
        end
        m_res = r; m_known = k; m_sp = s;
        pend_ov = 1'b1; pend_fault = f; pend_res = r; pend_known = k; pend_sp = s;
        @(negedge clk);
        InValid = 1'b0; cur_stall = 1'b0; pend_ov = 1'b0; pend_fault = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd;
        n_vec = 0; n_err = 0;
        for (int i = 0; i < 2048; i++) begin mk[i] = 1'b0; mm[i] = 16'h0; end
        rst = 1'b0; InValid = 1'b0; MemOp = OP_NOP; Address = 32'h0; DataIn = 32'h0;
        set_all_reset();
        checking = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("reset_sp", {21'h0, SP}, 32'h0000_07FF);
        chk("reset_result", Result, 32'h0);
        chk("reset_out_valid", {31'h0, OutValid}, 32'h0);

        for (int i = 0; i < 16; i++) issue(OP_STORE, i[10:0], $urandom, 1'b0);
        issue(OP_STORE, 11'd0, 32'h0000_F00D, 1'b0);

        issue(OP_PUSH16, 11'd0, 32'h0000_1234, 1'b0);
        chk("push16_sp", {21'h0, SP}, 32'h0000_07FE);
        issue(OP_POP16, 11'd0, 32'h0, 1'b0);
        chk("pop16_result", Result, 32'h0000_1234);
        chk("pop16_sp", {21'h0, SP}, 32'h0000_07FF);

        issue(OP_STORE, 11'd5, 32'h0000_8001, 1'b0);
        issue(OP_LOAD, 11'd5, 32'h0, 1'b0);
        chk("load_sext", Result, 32'hFFFF_8001);
        issue(OP_NOP, 11'd0, 32'h0000_ABCD, 1'b0);
        chk("nop_pass", Result, 32'h0000_ABCD);

        issue(OP_PUSH32, 11'd0, 32'hDEAD_BEEF, 1'b0);
        chk("push32_sp", {21'h0, SP}, 32'h0000_07FD);
        chk("push32_out_valid", {31'h0, OutValid}, 32'h1);
        issue(OP_POP32, 11'd0, 32'h0, 1'b0);
        chk("pop32_result", Result, 32'hDEAD_BEEF);
        chk("pop32_sp", {21'h0, SP}, 32'h0000_07FF);

        issue(OP_PUSH32, 11'd0, 32'hDEAD_BEEF, 1'b0);
        issue(OP_POP16, 11'd0, 32'h0, 1'b0);
        chk("layout_top_high", Result, 32'hFFFF_DEAD);
        issue(OP_POP16, 11'd0, 32'h0, 1'b0);
        chk("layout_next_low", Result, 32'hFFFF_BEEF);

        issue(OP_POP16, 11'd0, 32'h0, 1'b0);
`ifdef STACK_GUARD_EN
        chk("guard_fault", {31'h0, StackFault}, 32'h1);
        chk("guard_result", Result, 32'h0);
        chk("guard_sp", {21'h0, SP}, 32'h0000_07FF);
`else
        chk("wrap_result", Result, 32'hFFFF_F00D);
        chk("wrap_sp", {21'h0, SP}, 32'h0000_0000);
`endif

        issue(OP_PUSH16, 11'd0, 32'h0000_0777, 1'b0);
        do_reset();
        issue(OP_PUSH32, 11'd0, 32'h1111_2222, 1'b1);
        chk("abort_sp", {21'h0, SP}, 32'h0000_07FF);
        chk("abort_out_valid", {31'h0, OutValid}, 32'h0);
        issue(OP_LOAD, 11'h7FF, 32'h0, 1'b0);
        chk("abort_low_word", Result, 32'h0000_2222);
        issue(OP_PUSH16, 11'd0, 32'h0000_5555, 1'b0);
        issue(OP_POP16, 11'd0, 32'h0, 1'b0);
        chk("after_abort_pop", Result, 32'h0000_5555);

        for (int n = 0; n < 400; n++) begin
            rnd = $urandom;
            if (rnd[7:0] == 8'd0) begin
                do_reset();
            end else if (rnd[9:8] == 2'd0) begin
                MemOp = rnd[12:10];
                DataIn = $urandom;
                @(negedge clk);
            end else begin
                issue(rnd[15:13], {7'h0, rnd[19:16]}, $urandom, 1'b0);
            end
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
